imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Fetch-stage sequencer for the 5-stage pipeline. Generates the PC stream for the fixed-latency instruction memory.
//  Tracks reads in flight, buffers returned words in a small FIFO and hands {pc, instr} to decode on a valid/ready handshake.
//  Handles branch/jump redirects (stale words discarded) and a halt/resume request from the hazard/debug logic.
// PARAMETERS
//  RESET_PC    32'h0  first PC fetched after reset
//  MEM_LAT     1      cycles from imem_addr issue to imem_rdata valid (>=1)
//  FIFO_DEPTH  4      instruction buffer entries (power of 2, >=2)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   synchronous active-low reset
//  imem_addr    out  32  byte address to instruction memory (word index = addr>>2)
//  imem_req     out  1   imem_addr valid this cycle
//  imem_rdata   in   32  instruction word, valid MEM_LAT cycles after its req
//  redirect     in   1   taken branch/jump from EX; overrides all else
//  redirect_pc  in   32  target PC (bits[1:0] ignored, forced 0)
//  halt_req     in   1   level: stop issuing fetches
//  halted       out  1   no fetch in flight and issue stopped
//  if_valid     out  1   if_pc/if_instr valid to decode
//  if_ready     in   1   decode accepts (pop when if_valid&&if_ready)
//  if_pc        out  32  PC of presented instruction
//  if_instr     out  32  presented instruction word
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=BOOT, fetch_pc=RESET_PC, FIFO empty, inflight=0, epoch=0.
//    Outputs imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, halted=0.
//    Reset mid-operation discards in-flight reads: pending tags are cleared.
//  - States: BOOT -> RUN (unconditional, 1 cycle). RUN -> HALTING on halt_req.
//    HALTING -> HALTED when inflight==0. HALTED -> RUN when !halt_req.
//    redirect in any state except BOOT updates fetch_pc. It does not leave HALTING/HALTED.
//  - Issue: in RUN, imem_req=1 iff (count+inflight-pop) < FIFO_DEPTH. imem_addr=fetch_pc (combinational from reg).
//    On issue, fetch_pc += 4 (32-bit wrap, 32'hFFFFFFFC -> 0).
//  - Tracking: MEM_LAT-deep shift register of {valid, epoch, pc} per issue.
//    At tap MEM_LAT, if valid && tag epoch==epoch, push {pc, imem_rdata} to FIFO; otherwise drop.
//  - Redirect (cycle t): epoch toggles, FIFO flushed (count=0), fetch_pc=redirect_pc. No imem_req in cycle t.
//    First new req in t+1 with imem_addr=redirect_pc. if_valid=0 in t+1.
//    Redirect has priority over same-cycle pop, push and issue.
//  - if_valid = count!=0; if_pc/if_instr = FIFO head (registered storage). Head holds while !if_ready.
//    Simultaneous push+pop with count==FIFO_DEPTH is legal: credit rule guarantees no overflow.
//    Push to a full FIFO without pop is an assertion error.
//  - Throughput: MEM_LAT=1, FIFO_DEPTH>=2, if_ready=1 -> one instruction per cycle after 2-cycle fill.
//  - halted=1 only in HALTED. halt_req while redirect: redirect applied, then halt.
// CONFIGURATION
//  IMEM_FETCH_PERF_EN defined: adds outputs perf_fetched[31:0] (FIFO pushes) and perf_dropped[31:0] (stale
//    responses discarded). Both reset to 0, saturate at 32'hFFFFFFFF.
//  Undefined: ports and counters absent; functional behaviour identical.
// TESTING
//  1 reset, MEM_LAT=1, if_ready=1, IM[0..3] preloaded -> imem_addr 0,4,8,C on consecutive cycles.
//    if_pc 0,4,8,C with matching words; first if_valid 2 cycles after rst_n rises.
//  2 if_ready=0 for 10 cycles -> exactly FIFO_DEPTH(4) reqs issued, imem_req=0 afterwards.
//    if_pc holds 0. Release -> in-order drain, no loss or dup.
//  3 redirect=1, redirect_pc=32'h10 while 2 reads in flight (MEM_LAT=2) -> both responses dropped.
//    Next if_pc=0x10; perf_dropped=2 when IMEM_FETCH_PERF_EN.
//  4 halt_req asserted with inflight=1 -> halted=1 after response lands, imem_req stays 0.
//    Drop halt_req -> fetch resumes at next sequential PC.
//  5 fetch_pc=32'hFFFFFFFC issued -> next imem_addr=0. Redirect and pop in same cycle -> FIFO empty next cycle.
//  6 rst_n=0 mid-stream for 1 cycle -> all outputs at reset values, next fetch at RESET_PC, no stale push.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl -- fetch-stage sequencer for the 5-stage pipeline.
// Issues sequential PCs to a fixed-latency instruction memory, tags every
// read with the current epoch and buffers the returned words in a small FIFO.
// {pc, instr} are handed to decode on a valid/ready handshake.
// Redirects flush the buffer and discard stale words. halt_req stops issue.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   imem_addr/imem_req      read address / address valid to instruction memory
//   imem_rdata              word returned MEM_LAT cycles after its request
//   redirect/redirect_pc    taken branch/jump target from EX (bits[1:0] ignored)
//   halt_req/halted         level stop request / issue stopped with nothing in flight
//   if_valid/if_ready       handshake to decode
//   if_pc/if_instr          presented instruction
// Optional: define IMEM_FETCH_PERF_EN to add the saturating perf_fetched /
// perf_dropped counters (pushed words / discarded stale responses).
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALTING, S_HALTED} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               fetch_pc_q, fetch_pc_d;
  logic                      epoch_q, epoch_d;
  logic [MEM_LAT-1:0]        tv_q, tv_d;
  logic [MEM_LAT-1:0]        te_q, te_d;
  logic [MEM_LAT-1:0][31:0]  tpc_q, tpc_d;
  logic [31:0]               mem_pc_q    [FIFO_DEPTH];
  logic [31:0]               mem_pc_d    [FIFO_DEPTH];
  logic [31:0]               mem_instr_q [FIFO_DEPTH];
  logic [31:0]               mem_instr_d [FIFO_DEPTH];
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]             count_q, count_d;

  logic          redir, pop, push, issue, tap_v, tap_e;
  logic [31:0]   tap_pc, credit;
  logic [IW-1:0] inflight;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = &{1'b0, redirect_pc[1:0]};

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    epoch_d     = epoch_q;
    tv_d        = tv_q;
    te_d        = te_q;
    tpc_d       = tpc_q;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    redir  = redirect && (state_q != S_BOOT);
    pop    = (count_q != '0) && if_ready;
    tap_v  = tv_q[MEM_LAT-1];
    tap_e  = te_q[MEM_LAT-1];
    tap_pc = tpc_q[MEM_LAT-1];
    push   = tap_v && (tap_e == epoch_q) && !redir;

    inflight = '0;
    for (int unsigned i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + IW'(tv_q[i]);
    end
    // Slots already promised: buffered words plus reads still on their way.
    credit = 32'(count_q) + 32'(inflight) - 32'(pop);
    issue  = (state_q == S_RUN) && !redir && !halt_req && (credit < FIFO_DEPTH);

    case (state_q)
      S_BOOT:    state_d = S_RUN;
      S_RUN:     if (halt_req)       state_d = S_HALTING;
      S_HALTING: if (inflight == '0) state_d = S_HALTED;
      S_HALTED:  if (!halt_req)      state_d = S_RUN;
      default:   state_d = S_BOOT;
    endcase

    if (redir) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      epoch_d    = ~epoch_q;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    tv_d[0]  = issue;
    te_d[0]  = epoch_q;
    tpc_d[0] = fetch_pc_q;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      tv_d[i]  = tv_q[i-1];
      te_d[i]  = te_q[i-1];
      tpc_d[i] = tpc_q[i-1];
    end
    // Re-stamp every in-flight tag with the outgoing epoch so that a second
    // redirect toggling the epoch back cannot revive an older read.
    if (redir) begin
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        te_d[i] = epoch_q;
      end
    end

    if (redir) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_pc_d[wr_ptr_q]    = tap_pc;
        mem_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + AW'(push);
      end
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      fetch_pc_q  <= RESET_PC;
      epoch_q     <= 1'b0;
      tv_q        <= '0;
      te_q        <= '0;
      tpc_q       <= '0;
      mem_pc_q    <= '{default: '0};
      mem_instr_q <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      epoch_q     <= epoch_d;
      tv_q        <= tv_d;
      te_q        <= te_d;
      tpc_q       <= tpc_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign halted    = (state_q == S_HALTED);
  assign if_valid  = (count_q != '0);
  assign if_pc     = mem_pc_q[rd_ptr_q];
  assign if_instr  = mem_instr_q[rd_ptr_q];

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_dropped_d = perf_dropped_q;
    if (push && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 32'd1;
    if (tap_v && !push && (perf_dropped_q != '1)) perf_dropped_d = perf_dropped_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: one instance with MEM_LAT=1 and one
// with MEM_LAT=2 (redirect with two reads in flight). Inputs change and
// outputs are sampled just after the falling clock edge.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // instance 1: MEM_LAT=1
  logic [31:0] imem_addr, imem_rdata, redirect_pc, if_pc, if_instr;
  logic        imem_req, redirect, halt_req, halted, if_valid, if_ready;
  // instance 2: MEM_LAT=2
  logic [31:0] imem_addr2, imem_rdata2, redirect_pc2, if_pc2, if_instr2;
  logic        imem_req2, redirect2, halt_req2, halted2, if_valid2, if_ready2;

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_fetched2, perf_dropped2;
`endif

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Instruction memory models: data for an address valid MEM_LAT cycles later.
  logic [31:0] a1_q, b1_q, b2_q;
  always @(posedge clk) begin
    a1_q <= imem_addr;
    b1_q <= imem_addr2;
    b2_q <= b1_q;
  end
  assign imem_rdata  = word(a1_q);
  assign imem_rdata2 = word(b2_q);

  imem_fetch_ctrl #(.RESET_PC(32'h0), .MEM_LAT(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
`ifdef IMEM_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  imem_fetch_ctrl #(.RESET_PC(32'h0), .MEM_LAT(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr2), .imem_req(imem_req2), .imem_rdata(imem_rdata2),
    .redirect(redirect2), .redirect_pc(redirect_pc2),
    .halt_req(halt_req2), .halted(halted2),
    .if_valid(if_valid2), .if_ready(if_ready2), .if_pc(if_pc2), .if_instr(if_instr2)
`ifdef IMEM_FETCH_PERF_EN
    , .perf_fetched(perf_fetched2), .perf_dropped(perf_dropped2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},    32'(imem_req), 32'd0);
    chk({tag, "_addr"},   imem_addr,     32'h0);
    chk({tag, "_valid"},  32'(if_valid), 32'd0);
    chk({tag, "_pc"},     if_pc,         32'h0);
    chk({tag, "_instr"},  if_instr,      32'h0);
    chk({tag, "_halted"}, 32'(halted),   32'd0);
    chk({tag, "_req2"},   32'(imem_req2), 32'd0);
    chk({tag, "_valid2"}, 32'(if_valid2), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    redirect = 1'b0;  redirect_pc = '0;  halt_req = 1'b0;  if_ready = 1'b1;
    redirect2 = 1'b0; redirect_pc2 = '0; halt_req2 = 1'b0; if_ready2 = 1'b1;

    // Reset state (BOOT cycle follows the reset edge)
    next_cycle(); #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Sequential stream, one instruction per cycle after a 2-cycle fill
    for (int k = 0; k < 6; k++) begin
      next_cycle(); #1;
      chk("seq_req",  32'(imem_req), 32'd1);
      chk("seq_addr", imem_addr, 32'(4 * k));
      if (k >= 2) begin
        chk("seq_valid", 32'(if_valid), 32'd1);
        chk("seq_pc",    if_pc,    32'(4 * (k - 2)));
        chk("seq_instr", if_instr, word(32'(4 * (k - 2))));
      end else begin
        chk("seq_fill", 32'(if_valid), 32'd0);
      end
    end

    // Redirect with a same-cycle pop; target bits[1:0] ignored; PC wraps
    next_cycle(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB; #1;
    chk("redir_req",   32'(imem_req), 32'd0);
    chk("redir_head",  if_pc, 32'h10);
    next_cycle(); redirect = 1'b0; #1;
    chk("redir_empty", 32'(if_valid), 32'd0);
    chk("redir_req1",  32'(imem_req), 32'd1);
    chk("redir_addr1", imem_addr, 32'hFFFF_FFF8);
    next_cycle(); #1;
    chk("wrap_addr_fc", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_valid",   32'(if_valid), 32'd0);
    next_cycle(); #1;
    chk("wrap_addr0", imem_addr, 32'h0);
    chk("wrap_pc_f8", if_pc, 32'hFFFF_FFF8);
    chk("wrap_in_f8", if_instr, word(32'hFFFF_FFF8));
    next_cycle(); #1;
    chk("wrap_addr4", imem_addr, 32'h4);
    chk("wrap_pc_fc", if_pc, 32'hFFFF_FFFC);
    next_cycle(); #1;
    chk("wrap_addr8", imem_addr, 32'h8);
    chk("wrap_pc0",   if_pc, 32'h0);

    // Mid-stream reset for one cycle
    next_cycle(); rst_n = 1'b0; #1;
    next_cycle(); #1;
    chk_reset_outputs("mid_rst");
    rst_n = 1'b1; if_ready = 1'b0;

    // Decode stalled: exactly FIFO_DEPTH requests, head holds at PC 0
    for (int j = 0; j < 9; j++) begin
      next_cycle(); #1;
      chk("stall_req", 32'(imem_req), (j < 4) ? 32'd1 : 32'd0);
      if (j < 4) chk("stall_addr", imem_addr, 32'(4 * j));
      if (j >= 2) begin
        chk("stall_valid", 32'(if_valid), 32'd1);
        chk("stall_pc",    if_pc, 32'h0);
      end else begin
        chk("stall_fill", 32'(if_valid), 32'd0);
      end
    end

    // Release: in-order drain while fetch continues
    for (int j = 0; j < 6; j++) begin
      next_cycle(); if_ready = 1'b1; #1;
      chk("drain_req",   32'(imem_req), 32'd1);
      chk("drain_addr",  imem_addr, 32'(32'h10 + 4 * j));
      chk("drain_pc",    if_pc, 32'(4 * j));
      chk("drain_instr", if_instr, word(32'(4 * j)));
    end

    // Halt with one read in flight, then resume at the next sequential PC
    next_cycle(); halt_req = 1'b1; #1;
    chk("halt_req0",  32'(imem_req), 32'd0);
    chk("halt_h0",    32'(halted), 32'd0);
    next_cycle(); #1;
    chk("halting_req", 32'(imem_req), 32'd0);
    chk("halting_h",   32'(halted), 32'd0);
    next_cycle(); #1;
    chk("halted_h1",   32'(halted), 32'd1);
    chk("halted_req1", 32'(imem_req), 32'd0);
    next_cycle(); #1;
    chk("halted_h2",   32'(halted), 32'd1);
    chk("halted_req2", 32'(imem_req), 32'd0);
    next_cycle(); halt_req = 1'b0; #1;
    chk("unhalt_h",   32'(halted), 32'd1);
    chk("unhalt_req", 32'(imem_req), 32'd0);
    next_cycle(); #1;
    chk("resume_req",  32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h28);
    chk("resume_h",    32'(halted), 32'd0);

    // MEM_LAT=2 instance: redirect with two reads in flight
    next_cycle(); redirect2 = 1'b1; redirect_pc2 = 32'h10; #1;
    chk("r2_req",    32'(imem_req2), 32'd0);
    chk("r2_valid",  32'(if_valid2), 32'd1);
    next_cycle(); redirect2 = 1'b0; #1;
    chk("r2_req1",   32'(imem_req2), 32'd1);
    chk("r2_addr1",  imem_addr2, 32'h10);
    chk("r2_empty1", 32'(if_valid2), 32'd0);
    next_cycle(); #1;
    chk("r2_addr2",  imem_addr2, 32'h14);
    chk("r2_empty2", 32'(if_valid2), 32'd0);
    next_cycle(); #1;
    chk("r2_addr3",  imem_addr2, 32'h18);
    chk("r2_empty3", 32'(if_valid2), 32'd0);
    next_cycle(); #1;
    chk("r2_valid4", 32'(if_valid2), 32'd1);
    chk("r2_pc4",    if_pc2, 32'h10);
    chk("r2_instr4", if_instr2, word(32'h10));
`ifdef IMEM_FETCH_PERF_EN
    chk("r2_dropped", perf_dropped2, 32'd2);
`endif
    next_cycle(); #1;
    chk("r2_pc5",    if_pc2, 32'h14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
